// File: rtl/l2_line_responder.sv
// L2 responder: arbitrates per-thread L1 I-cache line requests and broadcasts returned lines.
// Define L2_PREFETCH_EN to let req_spec next-line prefetches take part as the lowest class.

package fgmt;
    typedef logic [31:0]  word;
    typedef logic [127:0] line;
    localparam int unsigned TID_bits = 2;
endpackage

module l2_line_responder #(
    parameter int unsigned NTHREADS = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NTHREADS-1:0]         br_req,
    input  logic [NTHREADS-1:0]         req_refill,
    input  logic [NTHREADS-1:0]         req_spec,
    input  fgmt::word [NTHREADS-1:0]    req_addr,
    output logic                        mem_req,
    output fgmt::word                   mem_addr,
    input  logic                        mem_ready,
    input  logic                        mem_rsp_valid,
    input  fgmt::line                   mem_rsp_line,
    output fgmt::word                   l2addr,
    output logic [fgmt::TID_bits-1:0]   l2_tid,
    output fgmt::line                   l2_line,
    output logic                        l2_valid_rsp
);
    import fgmt::*;

    typedef logic [TID_bits-1:0] tid_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e state_q, state_d;
    tid_t   rr_q, rr_d;
    logic   mask_vld_q, mask_vld_d;
    tid_t   mask_tid_q, mask_tid_d;
    tid_t   tid_q, tid_d;
    logic   mem_req_q, mem_req_d;
    word    mem_addr_q, mem_addr_d;
    logic   l2_valid_q, l2_valid_d;
    word    l2addr_q, l2addr_d;
    tid_t   l2_tid_q, l2_tid_d;
    line    l2_line_q, l2_line_d;

    logic [NTHREADS-1:0] unmask, cls_v;
    logic                pick_found;
    tid_t                pick_tid, cand;
    int unsigned         idx;
    word                 base, tgt;
    logic                unused_inputs;

    // Low address nibble is always replaced by the line offset; req_spec is dead without prefetch.
    assign unused_inputs = ^{req_addr, req_spec};

`ifdef L2_PREFETCH_EN
    logic spec_cls;
`endif

    always_comb begin
        unmask = '1;
        if (mask_vld_q) unmask[mask_tid_q] = 1'b0;
`ifdef L2_PREFETCH_EN
        spec_cls = 1'b0;
`endif
        if (|(br_req & unmask))          cls_v = br_req & unmask;
        else if (|(req_refill & unmask)) cls_v = req_refill & unmask;
        else begin
`ifdef L2_PREFETCH_EN
            cls_v    = req_spec & unmask;
            spec_cls = 1'b1;
`else
            cls_v    = '0;
`endif
        end

        pick_found = 1'b0;
        pick_tid   = '0;
        idx        = 0;
        cand       = '0;
        for (int unsigned i = 0; i < NTHREADS; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NTHREADS) idx = idx - NTHREADS;
            cand = tid_t'(idx);
            if (!pick_found && cls_v[cand]) begin
                pick_found = 1'b1;
                pick_tid   = cand;
            end
        end

        base = req_addr[pick_tid];
        tgt  = {base[31:4], 4'b0};
`ifdef L2_PREFETCH_EN
        if (spec_cls) tgt = {base[31:4] + 28'd1, 4'b0};
`endif
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        mask_vld_d = mask_vld_q;
        mask_tid_d = mask_tid_q;
        tid_d      = tid_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        l2_valid_d = 1'b0;
        l2addr_d   = l2addr_q;
        l2_tid_d   = l2_tid_q;
        l2_line_d  = l2_line_q;
        case (state_q)
            IDLE: begin
                mask_vld_d = 1'b0;
                if (pick_found) begin
                    state_d    = ISSUE;
                    tid_d      = pick_tid;
                    rr_d       = (32'(pick_tid) == NTHREADS - 1) ? '0 : pick_tid + tid_t'(1);
                    mem_req_d  = 1'b1;
                    mem_addr_d = tgt;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d    = RESP;
                    l2_valid_d = 1'b1;
                    l2addr_d   = mem_addr_q;
                    l2_tid_d   = tid_q;
                    l2_line_d  = mem_rsp_line;
                end
            end
            RESP: begin
                // Requester's level is still high this cycle; hide it from the next arbitration.
                state_d    = IDLE;
                mask_vld_d = 1'b1;
                mask_tid_d = tid_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            mask_vld_q <= 1'b0;
            mask_tid_q <= '0;
            tid_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            l2_valid_q <= 1'b0;
            l2addr_q   <= '0;
            l2_tid_q   <= '0;
            l2_line_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            mask_vld_q <= mask_vld_d;
            mask_tid_q <= mask_tid_d;
            tid_q      <= tid_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            l2_valid_q <= l2_valid_d;
            l2addr_q   <= l2addr_d;
            l2_tid_q   <= l2_tid_d;
            l2_line_q  <= l2_line_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign l2_valid_rsp = l2_valid_q;
    assign l2addr       = l2addr_q;
    assign l2_tid       = l2_tid_q;
    assign l2_line      = l2_line_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Bench for l2_line_responder: vector table plus scoreboard of expected broadcast responses.
module tb_l2_line_responder;
    localparam int unsigned NT = 4;
`ifdef L2_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NT-1:0]        br_req = '0, req_refill = '0, req_spec = '0;
    logic [NT-1:0][31:0]  req_addr = '0;
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic                 mem_ready = 1'b0;
    logic                 mem_rsp_valid = 1'b0;
    logic [127:0]         mem_rsp_line = '0;
    logic [31:0]          l2addr;
    logic [1:0]           l2_tid;
    logic [127:0]         l2_line;
    logic                 l2_valid_rsp;

    always #5 clock = ~clock;

    l2_line_responder #(.NTHREADS(NT)) dut (
        .clock(clock), .reset(reset),
        .br_req(br_req), .req_refill(req_refill), .req_spec(req_spec), .req_addr(req_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_line(mem_rsp_line),
        .l2addr(l2addr), .l2_tid(l2_tid), .l2_line(l2_line), .l2_valid_rsp(l2_valid_rsp)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [127:0] make_line(input logic [31:0] a);
        return {a ^ 32'h0F0F_0F0F, ~a, a + 32'h1111_1111, a};
    endfunction

    typedef struct packed {
        logic [1:0]  tid;
        logic [31:0] addr;
    } exp_t;
    exp_t sb[$];

    // Memory model: accepts after ready_delay cycles, answers rsp_delay cycles later.
    int unsigned ready_delay = 0, rsp_delay = 0;
    bit          rsp_hold = 1'b0;
    int unsigned wait_cnt = 0, rsp_cnt = 0, req_cycles = 0;
    bit          pending = 1'b0;
    logic [31:0] held_addr = '0, pend_addr = '0;

    always @(negedge clock) begin
        mem_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        if (mem_req) req_cycles++;
        if (pending) begin
            if (rsp_cnt >= rsp_delay && !rsp_hold) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_line = make_line(pend_addr);
                pending = 1'b0;
            end else rsp_cnt++;
        end else if (mem_req) begin
            if (wait_cnt == 0) begin
                held_addr = mem_addr;
                if (sb.size() > 0) check("mem_addr", mem_addr, sb[0].addr);
            end else check("mem_addr_stable", mem_addr, held_addr);
            if (wait_cnt >= ready_delay) begin
                mem_ready = 1'b1;
                pending = 1'b1;
                rsp_cnt = 0;
                pend_addr = mem_addr;
                wait_cnt = 0;
            end else wait_cnt++;
        end else wait_cnt = 0;
    end

    bit          prev_valid = 1'b0;
    int unsigned rsp_total = 0;

    always @(negedge clock) begin
        if (!reset && l2_valid_rsp) begin
            exp_t e;
            rsp_total++;
            check("rsp_pulse_width", prev_valid, 0);
            if (sb.size() == 0) check("rsp_unexpected", l2_valid_rsp, 0);
            else begin
                e = sb.pop_front();
                check("rsp_tid", l2_tid, e.tid);
                check("rsp_addr", l2addr, e.addr);
                check("rsp_line", l2_line, make_line(e.addr));
            end
        end
        prev_valid = l2_valid_rsp;
    end

    task automatic wait_rsp(input int unsigned max_cyc, output bit got);
        got = 1'b0;
        for (int unsigned i = 0; i < max_cyc && !got; i++) begin
            @(negedge clock);
            if (l2_valid_rsp) got = 1'b1;
        end
    endtask

    task automatic drive_req(input int unsigned cls, input int unsigned tid, input logic [31:0] a, input bit on);
        req_addr[tid] = a;
        case (cls)
            0: br_req[tid] = on;
            1: req_refill[tid] = on;
            default: req_spec[tid] = on;
        endcase
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        int unsigned cls;
        int unsigned tid;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        bit          served;
    } vec_t;
    vec_t vecs[6];

    initial begin
        bit          got;
        int unsigned base, rbase, n, nexp;

        vecs[0] = '{cls: 1, tid: 0, addr: 32'h0000_000F, exp_addr: 32'h0000_0000, served: 1'b1};
        vecs[1] = '{cls: 0, tid: 3, addr: 32'hDEAD_BEEF, exp_addr: 32'hDEAD_BEE0, served: 1'b1};
        vecs[2] = '{cls: 0, tid: 2, addr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFF0, served: 1'b1};
        vecs[3] = '{cls: 2, tid: 2, addr: 32'hFFFF_FFFC, exp_addr: 32'h0000_0000, served: PF};
        vecs[4] = '{cls: 2, tid: 0, addr: 32'h0000_1234, exp_addr: 32'h0000_1240, served: PF};
        vecs[5] = '{cls: 1, tid: 1, addr: 32'h8000_0010, exp_addr: 32'h8000_0010, served: 1'b1};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_l2_valid", l2_valid_rsp, 0);
        check("rst_l2addr", l2addr, 0);
        check("rst_l2_tid", l2_tid, 0);
        check("rst_l2_line", l2_line, 0);

        // Single refill with exact cycle timing
        sb.push_back('{tid: 2'd1, addr: 32'h0000_1230});
        drive_req(1, 1, 32'h0000_1234, 1'b1);
        @(negedge clock);
        check("t1_mem_req_c1", mem_req, 1);
        check("t1_mem_addr_c1", mem_addr, 32'h0000_1230);
        @(negedge clock);
        check("t1_no_rsp_c2", l2_valid_rsp, 0);
        @(negedge clock);
        check("t1_rsp_c3", l2_valid_rsp, 1);
        drive_req(1, 1, 32'h0000_1234, 1'b0);
        repeat (2) @(negedge clock);

        for (int unsigned i = 0; i < 6; i++) begin
            if (vecs[i].served) sb.push_back('{tid: 2'(vecs[i].tid), addr: vecs[i].exp_addr});
            base = req_cycles;
            drive_req(vecs[i].cls, vecs[i].tid, vecs[i].addr, 1'b1);
            wait_rsp(40, got);
            check($sformatf("vec%0d_served", i), got, vecs[i].served);
            drive_req(vecs[i].cls, vecs[i].tid, vecs[i].addr, 1'b0);
            repeat (2) @(negedge clock);
            check($sformatf("vec%0d_mem_req_cycles", i), req_cycles - base, vecs[i].served ? 1 : 0);
        end

        // Held level on one thread: the masked IDLE cycle stretches the gap to 5
        sb.push_back('{tid: 2'd0, addr: 32'h0000_7770});
        sb.push_back('{tid: 2'd0, addr: 32'h0000_7770});
        drive_req(1, 0, 32'h0000_7777, 1'b1);
        wait_rsp(40, got);
        check("mask_first_rsp", got, 1);
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (l2_valid_rsp) got = 1'b1;
        end
        check("mask_gap_cycles", n, 5);
        drive_req(1, 0, 32'h0000_7777, 1'b0);
        repeat (2) @(negedge clock);

        // Class priority across threads
        req_addr[0] = 32'h0000_0100;
        req_addr[2] = 32'h0000_2000;
        req_addr[3] = 32'h0003_0000;
        sb.push_back('{tid: 2'd3, addr: 32'h0003_0000});
        sb.push_back('{tid: 2'd2, addr: 32'h0000_2000});
        if (PF) sb.push_back('{tid: 2'd0, addr: 32'h0000_0110});
        nexp = PF ? 3 : 2;
        br_req[3] = 1'b1;
        req_refill[2] = 1'b1;
        req_spec[0] = 1'b1;
        for (int unsigned i = 0; i < nexp; i++) begin
            wait_rsp(40, got);
            check($sformatf("prio_rsp%0d", i), got, 1);
            br_req[l2_tid] = 1'b0;
            req_refill[l2_tid] = 1'b0;
            req_spec[l2_tid] = 1'b0;
        end
        base = req_cycles;
        repeat (20) @(negedge clock);
        check("prio_tail_quiet", req_cycles - base, 0);
        req_spec = '0;
        br_req = '0;
        req_refill = '0;

        // Round-robin from rr_ptr = 0
        reset_dut();
        req_addr[0] = 32'h0000_4008;
        req_addr[1] = 32'h0000_5000;
        for (int unsigned i = 0; i < 4; i++)
            sb.push_back('{tid: 2'(i % 2), addr: (i % 2 == 0) ? 32'h0000_4000 : 32'h0000_5000});
        req_refill[0] = 1'b1;
        req_refill[1] = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            wait_rsp(40, got);
            check($sformatf("rr_rsp%0d", i), got, 1);
        end
        req_refill = '0;
        repeat (2) @(negedge clock);

        // Memory stalls
        ready_delay = 5;
        rsp_delay = 7;
        sb.push_back('{tid: 2'd1, addr: 32'hABCD_EF00});
        base = rsp_total;
        drive_req(0, 1, 32'hABCD_EF01, 1'b1);
        wait_rsp(80, got);
        check("stall_rsp", got, 1);
        drive_req(0, 1, 32'hABCD_EF01, 1'b0);
        repeat (10) @(negedge clock);
        check("stall_one_pulse", rsp_total - base, 1);
        ready_delay = 0;
        rsp_delay = 0;

        // Reset while waiting for memory; the late response must be dropped
        rsp_hold = 1'b1;
        drive_req(1, 0, 32'h0000_9000, 1'b1);
        got = 1'b0;
        for (int unsigned i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (mem_req) got = 1'b1;
        end
        check("rstw_issue", got, 1);
        got = 1'b0;
        for (int unsigned i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (!mem_req) got = 1'b1;
        end
        check("rstw_reached_wait", got, 1);
        drive_req(1, 0, 32'h0000_9000, 1'b0);
        reset_dut();
        base = rsp_total;
        rbase = req_cycles;
        @(negedge clock);
        rsp_hold = 1'b0;
        repeat (10) @(negedge clock);
        check("rstw_no_rsp", rsp_total - base, 0);
        check("rstw_idle_no_mem_req", req_cycles - rbase, 0);
        check("rstw_valid_low", l2_valid_rsp, 0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
